instr_decode_stage: RTL and testbench

// Registered, flow-controlled successor to the combinational field splitter. Accepts MIPS instructions

---
 rtl/mips_isa_pkg.sv | 49 ++++
 rtl/instr_decode_stage_if.sv | 44 ++++
 rtl/instr_field_decode.sv | 51 +++++
 rtl/instr_decode_stage.sv | 120 ++++++++++++
 tb/tb_instr_decode_stage.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_isa_pkg.sv
// MIPS ISA definitions shared by the decode stage: opcodes, field
// positions, instruction classes, stage states and the decoded bundle.
package mips_isa_pkg;

   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_J     = 6'h02;
   localparam logic [5:0] OPC_JAL   = 6'h03;
   localparam logic [5:0] OPC_ANDI  = 6'h0C;
   localparam logic [5:0] OPC_ORI   = 6'h0D;
   localparam logic [5:0] OPC_XORI  = 6'h0E;

   // Least-significant bit of each instruction field
   localparam int OPC_LSB = 26;
   localparam int RS_LSB  = 21;
   localparam int RT_LSB  = 16;
   localparam int RD_LSB  = 11;
   localparam int SA_LSB  = 6;
   localparam int FUN_LSB = 0;

   typedef enum logic [1:0] {
      IC_R = 2'b00,
      IC_I = 2'b01,
      IC_J = 2'b10
   } iclass_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_FULL  = 2'b01,
      ST_SKID  = 2'b10
   } stage_state_t;

   // Width-independent part of a decoded instruction
   typedef struct packed {
      logic [5:0]  opc;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  sa;
      logic [5:0]  fun;
      logic [25:0] iindex;
      iclass_t     iclass;
   } fields_t;

   // Logical immediates are zero-extended; everything else sign-extends
   function automatic logic imm_is_zext(input logic [5:0] opc);
      return (opc == OPC_ANDI) || (opc == OPC_ORI) || (opc == OPC_XORI);
   endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// Upstream (fetch) and downstream (register read) connections of the
// decode stage.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its payload steady while valid is high and
// ready is low; ready may be high without valid. The stage keeps its
// outputs stable while out_valid && !out_ready.
interface instr_decode_stage_if
   import mips_isa_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PC_W = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [PC_W-1:0] in_pc;

   logic            out_valid;
   logic            out_ready;
   logic [5:0]      opc;
   logic [5:0]      fun;
   logic [4:0]      rs;
   logic [4:0]      rt;
   logic [4:0]      rd;
   logic [4:0]      sa;
   logic [XLEN-1:0] imm_ext;
   logic [25:0]     iindex;
   logic [PC_W-1:0] jtarget;
   iclass_t         iclass;
   logic [PC_W-1:0] out_pc;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, opc, fun, rs, rt, rd, sa,
             imm_ext, iindex, jtarget, iclass, out_pc
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, opc, fun, rs, rt, rd, sa,
             imm_ext, iindex, jtarget, iclass, out_pc
   );
endinterface

// File: rtl/instr_field_decode.sv
// Combinational field splitter: slices the instruction, extends the
// immediate, forms the J-type target and classifies the instruction.
module instr_field_decode
   import mips_isa_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input  logic [31:0]     instr,
   input  logic [PC_W-1:0] pc,
   output fields_t         fields,
   output logic [XLEN-1:0] imm_ext,
   output logic [PC_W-1:0] jtarget
);

   logic [5:0]      opc;
   logic [15:0]     imm16;
   logic [PC_W-1:0] pc_plus4;

   // Extract fields and derive immediate, jump target and class
   always_comb begin
      opc           = instr[OPC_LSB +: 6];
      imm16         = instr[15:0];
      fields.opc    = opc;
      fields.rs     = instr[RS_LSB +: 5];
      fields.rt     = instr[RT_LSB +: 5];
      fields.rd     = instr[RD_LSB +: 5];
      fields.sa     = instr[SA_LSB +: 5];
      fields.fun    = instr[FUN_LSB +: 6];
      fields.iindex = instr[25:0];

      if (opc == OPC_RTYPE) begin
         fields.iclass = IC_R;
      end else if ((opc == OPC_J) || (opc == OPC_JAL)) begin
         fields.iclass = IC_J;
      end else begin
         fields.iclass = IC_I;
      end

      if (imm_is_zext(opc)) begin
         imm_ext = XLEN'(imm16);
      end else begin
         imm_ext = XLEN'($signed(imm16));
      end

      // pc+4 wraps naturally at PC_W bits; only its region bits survive
      pc_plus4 = pc + PC_W'(4);
      jtarget  = (pc_plus4 & ~PC_W'(28'hFFF_FFFF)) | PC_W'({instr[25:0], 2'b00});
   end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage between fetch and register read. Decodes at the
// input, then holds the decoded bundle in a main register plus an optional
// skid register so a registered in_ready still sustains one per cycle.
module instr_decode_stage
   import mips_isa_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PC_W = 32,
   parameter bit SKID = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   instr_decode_stage_if.slave  bus,
   output stage_state_t         debug_state
);

   typedef struct packed {
      fields_t         f;
      logic [XLEN-1:0] imm_ext;
      logic [PC_W-1:0] jtarget;
      logic [PC_W-1:0] pc;
   } bundle_t;

   fields_t         dec_fields;
   logic [XLEN-1:0] dec_imm;
   logic [PC_W-1:0] dec_jt;
   bundle_t         dec;
   bundle_t         main_q, main_d;
   bundle_t         skid_q, skid_d;
   stage_state_t    state, state_d;
   logic            ready_q;
   logic            accept;

   instr_field_decode #(.XLEN(XLEN), .PC_W(PC_W)) u_field_decode (
      .instr   (bus.in_instr),
      .pc      (bus.in_pc),
      .fields  (dec_fields),
      .imm_ext (dec_imm),
      .jtarget (dec_jt)
   );

   assign dec = '{f: dec_fields, imm_ext: dec_imm, jtarget: dec_jt, pc: bus.in_pc};

   if (SKID) begin : g_skid
      // Registered ready, held low during reset
      assign bus.in_ready = ready_q && !reset;
   end else begin : g_noskid
      // Single register: accept whenever the slot is free or draining
      assign bus.in_ready = !reset && (!bus.out_valid || bus.out_ready);
   end

   // A flush drops whatever is arriving in the same cycle
   assign accept = bus.in_valid && bus.in_ready && !flush;

   // Next state and register loads; skid entry is always older than new input
   always_comb begin
      state_d = state;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state)
         ST_EMPTY: begin
            if (accept) begin
               main_d  = dec;
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (accept && bus.out_ready) begin
               main_d = dec;
            end else if (accept) begin
               skid_d  = dec;
               state_d = ST_SKID;
            end else if (bus.out_ready) begin
               state_d = ST_EMPTY;
            end
         end
         ST_SKID: begin
            if (bus.out_ready) begin
               main_d  = skid_q;
               state_d = ST_FULL;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush) begin
         state_d = ST_EMPTY;
      end
   end

   // State, data registers and registered ready
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b1;
      end else begin
         state   <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= (state_d != ST_SKID);
      end
   end

   assign bus.out_valid = (state != ST_EMPTY);
   assign bus.opc       = main_q.f.opc;
   assign bus.fun       = main_q.f.fun;
   assign bus.rs        = main_q.f.rs;
   assign bus.rt        = main_q.f.rt;
   assign bus.rd        = main_q.f.rd;
   assign bus.sa        = main_q.f.sa;
   assign bus.iindex    = main_q.f.iindex;
   assign bus.iclass    = main_q.f.iclass;
   assign bus.imm_ext   = main_q.imm_ext;
   assign bus.jtarget   = main_q.jtarget;
   assign bus.out_pc    = main_q.pc;
   assign debug_state   = state;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: one instance with the skid buffer and one
// without, fed from the same stimulus. Each instance has its own
// scoreboard; directed tasks add hand-computed field checks.
module tb_instr_decode_stage;
   import mips_isa_pkg::*;

   localparam int OUT_W = 156;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        drv_valid = 1'b0;
   logic        drv_ready = 1'b1;
   logic [31:0] drv_instr = '0;
   logic [31:0] drv_pc = '0;
   int          checks = 0;
   int          failures = 0;

   stage_state_t     state1, state0;
   logic [OUT_W-1:0] obs1, obs0;
   logic [OUT_W-1:0] exp_q [2][$];
   logic [OUT_W-1:0] prev_obs [2];
   logic             prev_stall [2];
   logic [5:0]       opc_tab [8];

   instr_decode_stage_if #(.XLEN(32), .PC_W(32)) bus1 ();
   instr_decode_stage_if #(.XLEN(32), .PC_W(32)) bus0 ();

   assign bus1.in_valid  = drv_valid;
   assign bus1.in_instr  = drv_instr;
   assign bus1.in_pc     = drv_pc;
   assign bus1.out_ready = drv_ready;
   assign bus0.in_valid  = drv_valid;
   assign bus0.in_instr  = drv_instr;
   assign bus0.in_pc     = drv_pc;
   assign bus0.out_ready = drv_ready;

   instr_decode_stage #(.XLEN(32), .PC_W(32), .SKID(1'b1)) dut1 (
      .clk(clk), .reset(reset), .flush(flush), .bus(bus1), .debug_state(state1)
   );
   instr_decode_stage #(.XLEN(32), .PC_W(32), .SKID(1'b0)) dut0 (
      .clk(clk), .reset(reset), .flush(flush), .bus(bus0), .debug_state(state0)
   );

   assign obs1 = {bus1.opc, bus1.rs, bus1.rt, bus1.rd, bus1.sa, bus1.fun, bus1.imm_ext,
                  bus1.iindex, bus1.jtarget, bus1.iclass, bus1.out_pc};
   assign obs0 = {bus0.opc, bus0.rs, bus0.rt, bus0.rd, bus0.sa, bus0.fun, bus0.imm_ext,
                  bus0.iindex, bus0.jtarget, bus0.iclass, bus0.out_pc};

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [OUT_W-1:0] model(input logic [31:0] instr, input logic [31:0] pc);
      logic [5:0]  opc;
      logic [31:0] lo;
      logic [31:0] imm;
      logic [31:0] jt;
      logic [1:0]  ic;
      opc = 6'(instr >> 26);
      lo  = instr & 32'h0000_FFFF;
      if (opc == 6'h0C || opc == 6'h0D || opc == 6'h0E) imm = lo;
      else if (lo >= 32'h0000_8000) imm = lo + 32'hFFFF_0000;
      else imm = lo;
      jt = ((pc + 32'd4) & 32'hF000_0000) + ((instr & 32'h03FF_FFFF) * 32'd4);
      ic = (opc == 6'h00) ? 2'b00 : ((opc == 6'h02 || opc == 6'h03) ? 2'b10 : 2'b01);
      return {opc, 5'(instr >> 21), 5'(instr >> 16), 5'(instr >> 11), 5'(instr >> 6),
              6'(instr), imm, 26'(instr), jt, ic, pc};
   endfunction

   // ---------------- scoreboard ----------------
   task automatic mon(input int d, input logic ov, input logic ir, input logic [OUT_W-1:0] obs);
      logic [OUT_W-1:0] e;
      if (reset) begin
         exp_q[d].delete();
         prev_stall[d] = 1'b0;
         return;
      end
      if (prev_stall[d]) begin
         checks++;
         if (ov !== 1'b1 || obs !== prev_obs[d]) begin
            failures++;
            $display("FAIL dut%0d_stall_stable got_valid=%b got=%h want=%h", d, ov, obs, prev_obs[d]);
         end
      end
      if (ov && drv_ready) begin
         checks++;
         if (exp_q[d].size() == 0) begin
            failures++;
            $display("FAIL dut%0d_unexpected_out got=%h want=none", d, obs);
         end else begin
            e = exp_q[d].pop_front();
            if (obs !== e) begin
               failures++;
               $display("FAIL dut%0d_out_order got=%h want=%h", d, obs, e);
            end
         end
      end
      if (flush) exp_q[d].delete();
      else if (drv_valid && ir) exp_q[d].push_back(model(drv_instr, drv_pc));
      prev_stall[d] = ov && !drv_ready && !flush;
      prev_obs[d]   = obs;
   endtask

   always @(negedge clk) begin
      mon(1, bus1.out_valid, bus1.in_ready, obs1);
      mon(0, bus0.out_valid, bus0.in_ready, obs0);
   end

   // ---------------- driver helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; drv_valid = 1'b0; drv_ready = 1'b1; flush = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      checks++; if (bus1.in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_high1 got=%b want=0", bus1.in_ready); end
      checks++; if (bus0.in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_high0 got=%b want=0", bus0.in_ready); end
      tick();
      reset = 1'b0;
      @(negedge clk);
      checks++; if (bus1.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid1 got=%b want=0", bus1.out_valid); end
      checks++; if (bus0.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid0 got=%b want=0", bus0.out_valid); end
      checks++; if (bus1.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready1 got=%b want=1", bus1.in_ready); end
      checks++; if (bus0.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready0 got=%b want=1", bus0.in_ready); end
      checks++; if (obs1 !== '0) begin failures++; $display("FAIL reset_fields1 got=%h want=0", obs1); end
      checks++; if (state1 !== ST_EMPTY) begin failures++; $display("FAIL reset_state1 got=%0d want=0", state1); end
   endtask

   task automatic test_rtype();
      tick();
      drv_ready = 1'b1; drv_valid = 1'b1; drv_instr = 32'h012A_4020; drv_pc = 32'h0040_0000;
      tick();
      drv_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus1.out_valid !== 1'b1) begin failures++; $display("FAIL rtype_valid got=%b want=1", bus1.out_valid); end
      checks++; if (bus1.opc !== 6'h00) begin failures++; $display("FAIL rtype_opc got=%h want=00", bus1.opc); end
      checks++; if (bus1.rs !== 5'd9) begin failures++; $display("FAIL rtype_rs got=%0d want=9", bus1.rs); end
      checks++; if (bus1.rt !== 5'd10) begin failures++; $display("FAIL rtype_rt got=%0d want=10", bus1.rt); end
      checks++; if (bus1.rd !== 5'd8) begin failures++; $display("FAIL rtype_rd got=%0d want=8", bus1.rd); end
      checks++; if (bus1.fun !== 6'h20) begin failures++; $display("FAIL rtype_fun got=%h want=20", bus1.fun); end
      checks++; if (bus1.iclass !== 2'b00) begin failures++; $display("FAIL rtype_iclass got=%b want=00", bus1.iclass); end
      checks++; if (bus1.out_pc !== 32'h0040_0000) begin failures++; $display("FAIL rtype_pc got=%h want=00400000", bus1.out_pc); end
      checks++; if (bus0.rd !== 5'd8) begin failures++; $display("FAIL rtype_rd0 got=%0d want=8", bus0.rd); end
   endtask

   task automatic test_imm();
      tick();
      drv_ready = 1'b1; drv_valid = 1'b1; drv_instr = 32'h2128_FFFF; drv_pc = 32'h0040_0004;
      tick();
      drv_instr = 32'h3528_FFFF; drv_pc = 32'h0040_0008;
      @(negedge clk);
      checks++; if (bus1.imm_ext !== 32'hFFFF_FFFF) begin failures++; $display("FAIL addi_imm got=%h want=ffffffff", bus1.imm_ext); end
      checks++; if (bus1.opc !== 6'h08) begin failures++; $display("FAIL addi_opc got=%h want=08", bus1.opc); end
      checks++; if (bus1.iclass !== 2'b01) begin failures++; $display("FAIL addi_iclass got=%b want=01", bus1.iclass); end
      checks++; if (bus0.imm_ext !== 32'hFFFF_FFFF) begin failures++; $display("FAIL addi_imm0 got=%h want=ffffffff", bus0.imm_ext); end
      tick();
      drv_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus1.imm_ext !== 32'h0000_FFFF) begin failures++; $display("FAIL ori_imm got=%h want=0000ffff", bus1.imm_ext); end
      checks++; if (bus1.opc !== 6'h0D) begin failures++; $display("FAIL ori_opc got=%h want=0d", bus1.opc); end
      checks++; if (bus1.rt !== 5'd8) begin failures++; $display("FAIL ori_rt got=%0d want=8", bus1.rt); end
      checks++; if (bus1.iclass !== 2'b01) begin failures++; $display("FAIL ori_iclass got=%b want=01", bus1.iclass); end
   endtask

   task automatic test_jal();
      tick();
      drv_ready = 1'b1; drv_valid = 1'b1; drv_instr = 32'h0C10_0004; drv_pc = 32'hF000_0000;
      tick();
      drv_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      checks++; if (bus1.iindex !== 26'h010_0004) begin failures++; $display("FAIL jal_iindex got=%h want=0100004", bus1.iindex); end
      checks++; if (bus1.jtarget !== 32'hF040_0010) begin failures++; $display("FAIL jal_jtarget got=%h want=f0400010", bus1.jtarget); end
      checks++; if (bus1.iclass !== 2'b10) begin failures++; $display("FAIL jal_iclass got=%b want=10", bus1.iclass); end
      checks++; if (bus1.opc !== 6'h03) begin failures++; $display("FAIL jal_opc got=%h want=03", bus1.opc); end
      tick();
      drv_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus1.jtarget !== 32'h0040_0010) begin failures++; $display("FAIL jal_wrap_jtarget got=%h want=00400010", bus1.jtarget); end
      checks++; if (bus1.out_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL jal_wrap_pc got=%h want=fffffffc", bus1.out_pc); end
   endtask

   task automatic test_back_to_back();
      tick();
      drv_ready = 1'b1; drv_valid = 1'b1; drv_instr = 32'h2128_0010; drv_pc = 32'h0000_0400;
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (i < 4) begin
            drv_pc    = 32'h0000_0400 + 32'(4 * i);
            drv_instr = drv_instr + 32'h0001_0000;
         end else begin
            drv_valid = 1'b0;
         end
         @(negedge clk);
         checks++;
         if (bus1.out_valid !== 1'b1 || bus1.out_pc !== 32'h0000_0400 + 32'(4 * (i - 1))) begin
            failures++;
            $display("FAIL b2b_pc1 step=%0d got_valid=%b got=%h want=%h", i, bus1.out_valid, bus1.out_pc, 32'h400 + 32'(4 * (i - 1)));
         end
         checks++;
         if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 32'h0000_0400 + 32'(4 * (i - 1))) begin
            failures++;
            $display("FAIL b2b_pc0 step=%0d got_valid=%b got=%h want=%h", i, bus0.out_valid, bus0.out_pc, 32'h400 + 32'(4 * (i - 1)));
         end
      end
   endtask

   task automatic test_skid();
      logic [31:0] pcs [4];
      int          n;
      logic        taken;
      tick();
      drv_ready = 1'b0; drv_valid = 1'b1; drv_instr = 32'h012A_4020; drv_pc = 32'h0000_0100;
      tick();
      drv_instr = 32'h2128_FFFF; drv_pc = 32'h0000_0104;
      @(negedge clk);
      checks++; if (bus1.in_ready !== 1'b1) begin failures++; $display("FAIL skid_ready_full got=%b want=1", bus1.in_ready); end
      checks++; if (state1 !== ST_FULL) begin failures++; $display("FAIL skid_state_full got=%0d want=1", state1); end
      tick();
      drv_instr = 32'h0C10_0004; drv_pc = 32'h0000_0108;
      @(negedge clk);
      checks++; if (bus1.in_ready !== 1'b0) begin failures++; $display("FAIL skid_ready_skid got=%b want=0", bus1.in_ready); end
      checks++; if (state1 !== ST_SKID) begin failures++; $display("FAIL skid_state_skid got=%0d want=2", state1); end
      checks++; if (bus1.out_pc !== 32'h0000_0100) begin failures++; $display("FAIL skid_head_pc got=%h want=00000100", bus1.out_pc); end
      tick();
      @(negedge clk);
      checks++; if (bus1.in_ready !== 1'b0) begin failures++; $display("FAIL skid_ready_hold got=%b want=0", bus1.in_ready); end
      tick();
      drv_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus1.out_valid === 1'b1 && n < 4) begin
            pcs[n] = bus1.out_pc;
            n++;
         end
         taken = drv_valid && bus1.in_ready;
         tick();
         if (taken) drv_valid = 1'b0;
      end
      checks++; if (n != 3) begin failures++; $display("FAIL skid_count got=%0d want=3", n); end
      checks++; if (n > 0 && pcs[0] !== 32'h0000_0100) begin failures++; $display("FAIL skid_order0 got=%h want=00000100", pcs[0]); end
      checks++; if (n > 1 && pcs[1] !== 32'h0000_0104) begin failures++; $display("FAIL skid_order1 got=%h want=00000104", pcs[1]); end
      checks++; if (n > 2 && pcs[2] !== 32'h0000_0108) begin failures++; $display("FAIL skid_order2 got=%h want=00000108", pcs[2]); end
   endtask

   task automatic test_flush();
      tick();
      drv_ready = 1'b0; drv_valid = 1'b1; drv_instr = 32'h3528_FFFF; drv_pc = 32'h0000_0200;
      tick();
      drv_instr = 32'h012A_4020; drv_pc = 32'h0000_0204;
      tick();
      drv_instr = 32'h0C10_0004; drv_pc = 32'h0000_0208; flush = 1'b1;
      @(negedge clk);
      checks++; if (state1 !== ST_SKID) begin failures++; $display("FAIL flush_pre_state got=%0d want=2", state1); end
      tick();
      flush = 1'b0; drv_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus1.out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid1 got=%b want=0", bus1.out_valid); end
      checks++; if (bus1.in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready1 got=%b want=1", bus1.in_ready); end
      checks++; if (state1 !== ST_EMPTY) begin failures++; $display("FAIL flush_state1 got=%0d want=0", state1); end
      checks++; if (bus0.out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid0 got=%b want=0", bus0.out_valid); end
      tick();
      drv_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus1.out_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%b want=0", bus1.out_valid); end
   endtask

   task automatic test_reset_mid();
      tick();
      drv_ready = 1'b0; drv_valid = 1'b1; drv_instr = 32'h2128_1234; drv_pc = 32'h0000_0300;
      tick();
      drv_instr = 32'h3528_8000; drv_pc = 32'h0000_0304;
      tick();
      reset = 1'b1; drv_instr = 32'h0800_0001; drv_pc = 32'h0000_0308;
      tick();
      @(negedge clk);
      checks++; if (bus1.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid1 got=%b want=0", bus1.out_valid); end
      checks++; if (obs1 !== '0) begin failures++; $display("FAIL midrst_fields1 got=%h want=0", obs1); end
      checks++; if (bus0.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid0 got=%b want=0", bus0.out_valid); end
      checks++; if (obs0 !== '0) begin failures++; $display("FAIL midrst_fields0 got=%h want=0", obs0); end
      tick();
      reset = 1'b0; drv_valid = 1'b0; drv_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus1.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready1 got=%b want=1", bus1.in_ready); end
      checks++; if (bus1.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_after_valid1 got=%b want=0", bus1.out_valid); end
   endtask

   task automatic test_stress();
      opc_tab = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23};
      for (int i = 0; i < 800; i++) begin
         tick();
         drv_valid = ($urandom_range(0, 3) != 0);
         drv_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 30) == 0);
         drv_instr = $urandom();
         drv_instr[31:26] = opc_tab[$urandom_range(0, 7)];
         drv_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom();
      end
      tick();
      drv_valid = 1'b0; flush = 1'b0; drv_ready = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      checks++; if (exp_q[1].size() != 0) begin failures++; $display("FAIL stress_left1 got=%0d want=0", exp_q[1].size()); end
      checks++; if (exp_q[0].size() != 0) begin failures++; $display("FAIL stress_left0 got=%0d want=0", exp_q[0].size()); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      prev_stall[0] = 1'b0;
      prev_stall[1] = 1'b0;
      test_reset();
      test_rtype();
      test_imm();
      test_jal();
      test_back_to_back();
      test_skid();
      test_flush();
      test_reset_mid();
      test_stress();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
